// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer and the rest of the pixel-clock domain.
// The sequencer side uses the slave modport; whoever drives locked/restart uses master.
interface pll_reset_sequencer_if;
  logic       locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       fault;
  logic       lock_lost;
  logic [7:0] loss_count;
  logic [2:0] state;

  modport master (
    output locked,
    output restart,
    input  pll_rst,
    input  sys_rst_n,
    input  fault,
    input  lock_lost,
    input  loss_count,
    input  state
  );

  modport slave (
    input  locked,
    input  restart,
    output pll_rst,
    output sys_rst_n,
    output fault,
    output lock_lost,
    output loss_count,
    output state
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL power-up / lock supervisor in the refclk domain: timed PLL reset, lock wait with
// bounded retries, lock-stability qualification and re-sequencing on loss of lock.
module pll_reset_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = 16
) (
  input  logic                 refclk,
  input  logic                 rst_n,
  pll_reset_sequencer_if.slave bus
);

  localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABILIZE  = 3'd2,
    RUN        = 3'd3,
    FAULT      = 3'd4
  } state_e;

  state_e             r_state;
  state_e             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [RETRY_W-1:0] r_retry_cnt;
  logic [RETRY_W-1:0] w_next_retry;
  logic               w_clear_cnt;
  logic               w_lost;
  logic               w_retry;

  logic               r_locked_meta;
  logic               r_locked_s;

  logic               r_pll_rst;
  logic               r_sys_rst_n;
  logic               r_fault;
  logic               r_lock_lost;
  logic [7:0]         r_loss_count;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked_meta <= 1'b0;
      r_locked_s    <= 1'b0;
    end else begin
      r_locked_meta <= bus.locked;
      r_locked_s    <= r_locked_meta;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_retry = r_retry_cnt;
    w_lost       = 1'b0;
    w_retry      = 1'b0;

    if (bus.restart) begin
      w_next_state = RESET_HOLD;
      w_next_retry = '0;
    end else begin
      case (r_state)
        RESET_HOLD: begin
          if (r_cnt == HOLD_LAST) w_next_state = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (r_locked_s)                  w_next_state = STABILIZE;
          else if (r_cnt == TIMEOUT_LAST)  w_retry      = 1'b1;
        end
        STABILIZE: begin
          if (!r_locked_s) begin
            w_retry = 1'b1;
          end else if (r_cnt == STABLE_LAST) begin
            w_next_state = RUN;
            w_next_retry = '0;
          end
        end
        RUN: begin
          if (!r_locked_s) begin
            w_lost       = 1'b1;
            w_next_state = RESET_HOLD;
          end
        end
        FAULT:   w_next_state = FAULT;
        default: w_next_state = RESET_HOLD;
      endcase

      if (w_retry) begin
        if (r_retry_cnt == RETRY_LAST) begin
          w_next_state = FAULT;
        end else begin
          w_next_state = RESET_HOLD;
          w_next_retry = r_retry_cnt + 1'b1;
        end
      end
    end
  end

  // restart also clears the counter so a restart issued during RESET_HOLD re-times the full hold
  assign w_clear_cnt = (w_next_state != r_state) || bus.restart;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RESET_HOLD;
      r_cnt       <= '0;
      r_retry_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      r_retry_cnt <= w_next_retry;
      r_cnt       <= w_clear_cnt ? '0 : r_cnt + 1'b1;
    end
  end

  // Outputs are registered from the next state so they change exactly with r_state
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_pll_rst    <= 1'b1;
      r_sys_rst_n  <= 1'b0;
      r_fault      <= 1'b0;
      r_lock_lost  <= 1'b0;
      r_loss_count <= '0;
    end else begin
      r_pll_rst   <= (w_next_state == RESET_HOLD) || (w_next_state == FAULT);
      r_sys_rst_n <= (w_next_state == RUN);
      r_fault     <= (w_next_state == FAULT);
      r_lock_lost <= w_lost;
      if (w_lost && (r_loss_count != '1)) r_loss_count <= r_loss_count + 1'b1;
    end
  end

  assign bus.pll_rst    = r_pll_rst;
  assign bus.sys_rst_n  = r_sys_rst_n;
  assign bus.fault      = r_fault;
  assign bus.lock_lost  = r_lock_lost;
  assign bus.loss_count = r_loss_count;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: stimulus queues time-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pll_reset_sequencer;

  typedef enum int {
    SIG_PLL_RST, SIG_SYS_RST_N, SIG_FAULT, SIG_LOCK_LOST, SIG_LOSS_COUNT, SIG_STATE, SIG_RETRY
  } sig_e;

  typedef struct {
    int    cyc;
    sig_e  sig;
    int    val;
    string tag;
  } exp_t;

  logic  refclk = 1'b0;
  logic  rst_n;
  int    edge_n   = 0;
  int    n_checks = 0;
  int    n_fail   = 0;
  exp_t  sb[$];

  pll_reset_sequencer_if bus();

  pll_reset_sequencer #(
    .RST_HOLD_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2),
    .CNT_W               (16)
  ) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #10 refclk = ~refclk;
  always @(posedge refclk) edge_n <= edge_n + 1;

  function automatic int sample(sig_e s);
    case (s)
      SIG_PLL_RST:    return int'(bus.pll_rst);
      SIG_SYS_RST_N:  return int'(bus.sys_rst_n);
      SIG_FAULT:      return int'(bus.fault);
      SIG_LOCK_LOST:  return int'(bus.lock_lost);
      SIG_LOSS_COUNT: return int'(bus.loss_count);
      SIG_STATE:      return int'(bus.state);
      SIG_RETRY:      return int'(dut.r_retry_cnt);
      default:        return -1;
    endcase
  endfunction

  function automatic void compare(string tag, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, edge_n, act, req);
    end
  endfunction

  // Insert keeping the queue ordered by cycle so the monitor only looks at the head
  function automatic void expect_at(int c, sig_e s, int v, string tag);
    exp_t e;
    int   idx;
    e.cyc = c; e.sig = s; e.val = v; e.tag = tag;
    idx = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > c) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endfunction

  always @(negedge refclk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
      e = sb.pop_front();
      if (e.cyc < edge_n) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: expectation for edge %0d missed (now %0d), expected %0d", e.tag, e.cyc, edge_n, e.val);
      end else begin
        compare(e.tag, sample(e.sig), e.val);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge refclk);
  endtask

  // From RUN: drop locked for two edges, relock while the hold is still running
  task automatic lose_and_relock(int exp_loss, bit full);
    int e;
    e = edge_n;
    bus.locked = 1'b0;
    expect_at(e + 3, SIG_LOSS_COUNT, exp_loss, "loss_count_after_loss");
    expect_at(e + 16, SIG_STATE, 3, "state_rerun");
    if (full) begin
      expect_at(e + 2, SIG_SYS_RST_N, 1, "sys_rst_n_before_loss");
      expect_at(e + 2, SIG_LOCK_LOST, 0, "lock_lost_before");
      expect_at(e + 3, SIG_SYS_RST_N, 0, "sys_rst_n_on_loss");
      expect_at(e + 3, SIG_PLL_RST, 1, "pll_rst_on_loss");
      expect_at(e + 3, SIG_LOCK_LOST, 1, "lock_lost_pulse");
      expect_at(e + 3, SIG_STATE, 0, "state_hold_on_loss");
      expect_at(e + 4, SIG_LOCK_LOST, 0, "lock_lost_one_cycle");
      expect_at(e + 6, SIG_PLL_RST, 1, "pll_rst_stale_lock_hold");
      expect_at(e + 7, SIG_PLL_RST, 0, "pll_rst_hold_end");
      expect_at(e + 8, SIG_STATE, 2, "state_stab_after_relock");
      expect_at(e + 15, SIG_SYS_RST_N, 0, "sys_rst_n_pre_rerun");
      expect_at(e + 16, SIG_SYS_RST_N, 1, "sys_rst_n_rerun");
    end
    tick(2);
    bus.locked = 1'b1;
    tick(14);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time budget at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, r, k, a, f, g;
    int guard;

    rst_n       = 1'b1;
    bus.locked  = 1'b0;
    bus.restart = 1'b0;
    #5 rst_n = 1'b0;

    // Reset values and hold length after release, then first lock
    tick(2);
    t = edge_n;
    expect_at(t + 1, SIG_STATE, 0, "reset_state");
    expect_at(t + 1, SIG_PLL_RST, 1, "reset_pll_rst");
    expect_at(t + 1, SIG_SYS_RST_N, 0, "reset_sys_rst_n");
    expect_at(t + 1, SIG_FAULT, 0, "reset_fault");
    expect_at(t + 1, SIG_LOCK_LOST, 0, "reset_lock_lost");
    expect_at(t + 1, SIG_LOSS_COUNT, 0, "reset_loss_count");
    tick(1);
    rst_n = 1'b1;
    r = edge_n;
    expect_at(r + 3, SIG_PLL_RST, 1, "pll_rst_hold_last");
    expect_at(r + 4, SIG_PLL_RST, 0, "pll_rst_hold_released");
    expect_at(r + 4, SIG_STATE, 1, "state_wait_lock");
    tick(10);
    bus.locked = 1'b1;
    k = edge_n + 1;
    expect_at(k + 1, SIG_STATE, 1, "state_still_wait");
    expect_at(k + 2, SIG_STATE, 2, "state_stabilize");
    expect_at(k + 9, SIG_SYS_RST_N, 0, "sys_rst_n_before_run");
    expect_at(k + 10, SIG_SYS_RST_N, 1, "sys_rst_n_run");
    expect_at(k + 10, SIG_STATE, 3, "state_run");
    tick(11);

    // Lock losses in RUN, including saturation of loss_count
    for (int i = 1; i <= 300; i++) begin
      lose_and_relock((i > 255) ? 255 : i, i == 1);
    end

    // Permanent lock loss: three timed-out attempts then FAULT
    bus.locked = 1'b0;
    a = edge_n + 3;
    expect_at(a, SIG_STATE, 0, "state_hold_before_fault");
    expect_at(a, SIG_LOCK_LOST, 1, "lock_lost_saturated");
    expect_at(a, SIG_LOSS_COUNT, 255, "loss_count_saturated");
    expect_at(a + 4, SIG_STATE, 1, "attempt1_wait");
    expect_at(a + 24, SIG_STATE, 0, "attempt2_hold");
    expect_at(a + 24, SIG_RETRY, 1, "retry_after_attempt1");
    expect_at(a + 48, SIG_STATE, 0, "attempt3_hold");
    expect_at(a + 48, SIG_RETRY, 2, "retry_after_attempt2");
    expect_at(a + 71, SIG_PLL_RST, 0, "pll_rst_last_wait");
    expect_at(a + 71, SIG_FAULT, 0, "fault_not_yet");
    expect_at(a + 72, SIG_FAULT, 1, "fault_asserted");
    expect_at(a + 72, SIG_STATE, 4, "state_fault");
    for (int c = a; c <= a + 80; c++) expect_at(c, SIG_SYS_RST_N, 0, "sys_rst_n_low_no_lock");
    for (int c = a + 72; c <= a + 80; c++) expect_at(c, SIG_PLL_RST, 1, "pll_rst_fault_steady");
    tick(a + 80 - edge_n);

    // restart from FAULT
    f = edge_n;
    bus.restart = 1'b1;
    expect_at(f + 1, SIG_STATE, 0, "restart_state");
    expect_at(f + 1, SIG_FAULT, 0, "restart_fault_clear");
    expect_at(f + 1, SIG_RETRY, 0, "restart_retry_clear");
    expect_at(f + 1, SIG_LOSS_COUNT, 255, "restart_keeps_loss_count");
    for (int c = f + 1; c <= f + 4; c++) expect_at(c, SIG_PLL_RST, 1, "restart_pll_rst_hold");
    expect_at(f + 5, SIG_PLL_RST, 0, "restart_pll_rst_release");
    tick(1);
    bus.restart = 1'b0;

    // Brief lock dropout midway through STABILIZE
    tick(4);
    bus.locked = 1'b1;
    expect_at(f + 8, SIG_STATE, 2, "dropout_stabilize");
    tick(5);
    bus.locked = 1'b0;
    expect_at(f + 12, SIG_STATE, 2, "dropout_still_stab");
    expect_at(f + 13, SIG_STATE, 0, "dropout_to_hold");
    expect_at(f + 13, SIG_RETRY, 1, "dropout_retry_one");
    expect_at(f + 13, SIG_PLL_RST, 1, "dropout_pll_rst");
    tick(3);
    bus.locked = 1'b1;
    expect_at(f + 17, SIG_STATE, 1, "dropout_wait");
    expect_at(f + 18, SIG_STATE, 2, "dropout_restab");
    expect_at(f + 25, SIG_SYS_RST_N, 0, "dropout_sys_low");
    expect_at(f + 25, SIG_RETRY, 1, "dropout_retry_held");
    expect_at(f + 26, SIG_SYS_RST_N, 1, "dropout_sys_high");
    expect_at(f + 26, SIG_RETRY, 0, "dropout_retry_cleared");
    expect_at(f + 26, SIG_STATE, 3, "dropout_run");
    tick(13);

    // Asynchronous reset in the middle of STABILIZE
    g = edge_n;
    bus.locked = 1'b0;
    expect_at(g + 3, SIG_STATE, 0, "pre_areset_hold");
    tick(2);
    bus.locked = 1'b1;
    expect_at(g + 8, SIG_STATE, 2, "pre_areset_stab");
    expect_at(g + 10, SIG_STATE, 2, "pre_areset_stab_mid");
    expect_at(g + 10, SIG_PLL_RST, 0, "pre_areset_pll_rst");
    expect_at(g + 10, SIG_LOSS_COUNT, 255, "pre_areset_loss_count");
    tick(9);
    rst_n = 1'b0;
    #1;
    compare("areset_state", sample(SIG_STATE), 0);
    compare("areset_pll_rst", sample(SIG_PLL_RST), 1);
    compare("areset_sys_rst_n", sample(SIG_SYS_RST_N), 0);
    compare("areset_fault", sample(SIG_FAULT), 0);
    compare("areset_lock_lost", sample(SIG_LOCK_LOST), 0);
    compare("areset_loss_count", sample(SIG_LOSS_COUNT), 0);
    compare("areset_retry", sample(SIG_RETRY), 0);
    tick(2);
    rst_n = 1'b1;
    r = edge_n;
    expect_at(r + 1, SIG_PLL_RST, 1, "post_areset_hold");
    expect_at(r + 3, SIG_PLL_RST, 1, "post_areset_hold_last");
    expect_at(r + 4, SIG_PLL_RST, 0, "post_areset_release");
    expect_at(r + 4, SIG_STATE, 1, "post_areset_wait");
    expect_at(r + 5, SIG_STATE, 2, "post_areset_stab");
    expect_at(r + 12, SIG_SYS_RST_N, 0, "post_areset_sys_low");
    expect_at(r + 13, SIG_SYS_RST_N, 1, "post_areset_sys_high");
    expect_at(r + 13, SIG_STATE, 3, "post_areset_run");
    expect_at(r + 13, SIG_LOSS_COUNT, 0, "post_areset_loss_count");

    guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      tick(1);
      guard++;
    end
    compare("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Power-up and lock-supervision controller for the 50 MHz → 108 MHz pixel-clock PLL. It holds the PLL in reset for a fixed time, then waits for `locked` with a timeout and bounded retries. It requires `locked` to stay stable before releasing the downstream system reset, and it re-sequences the PLL on any loss of lock. It runs entirely in the `refclk` domain, drives the PLL `rst` input, and provides the reset and status that the video/audio pipeline consumes.

## Interface
- `RST_HOLD_CYCLES`, default 16: cycles `pll_rst` is held high per attempt.
- `LOCK_TIMEOUT_CYCLES`, default 50000: cycles to wait for `locked` per attempt (1 ms).
- `LOCK_STABLE_CYCLES`, default 1024: cycles `locked` must stay high before release.
- `MAX_RETRIES`, default 3: re-attempts after the first before declaring a fault.
- `CNT_W`, default 16: width of the shared cycle counter. Every cycle parameter must be ≥1 and < 2^CNT_W.

Ports:
- `refclk`, in, 1: 50 MHz reference clock. This is the block's only clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `locked`, in, 1: PLL lock. It is asynchronous to `refclk`.
- `restart`, in, 1: single-cycle request to restart the sequence.
- `pll_rst`, out, 1: active-high reset to the PLL.
- `sys_rst_n`, out, 1: active-low downstream reset. High only in RUN.
- `fault`, out, 1: retries exhausted.
- `lock_lost`, out, 1: one-cycle pulse when lock drops in RUN.
- `loss_count`, out, 8: number of lock losses in RUN. Saturates at 255.
- `state`, out, 3: current state encoding, for debug.

## Operation
- `locked` passes through a 2-flop synchronizer to produce `locked_s`. Only `locked_s` is used.
- There is one `CNT_W` counter. It is cleared on every state transition and increments otherwise.
- `retry_cnt` is `clog2(MAX_RETRIES+1)` bits wide.
- State encodings: RESET_HOLD=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAULT=4.
- RESET_HOLD:
  - `pll_rst`=1.
  - When counter == RST_HOLD_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK:
  - `pll_rst`=0.
  - If `locked_s`=1, go to STABILIZE.
  - Otherwise, when counter == LOCK_TIMEOUT_CYCLES-1, take the retry rule.
- STABILIZE:
  - `pll_rst`=0.
  - If `locked_s`=0, take the retry rule.
  - Otherwise, when counter == LOCK_STABLE_CYCLES-1, go to RUN.
- Retry rule:
  - If `retry_cnt` == MAX_RETRIES, go to FAULT.
  - Otherwise increment `retry_cnt` and go to RESET_HOLD.
- RUN:
  - `pll_rst`=0 and `sys_rst_n`=1.
  - `retry_cnt` is cleared on entry.
  - If `locked_s`=0: pulse `lock_lost`, increment `loss_count` (saturating), go to RESET_HOLD.
- FAULT:
  - `pll_rst`=1 and `fault`=1.
  - The block stays here until `restart` or `rst_n`.
- `restart` in any state:
  - Next state is RESET_HOLD.
  - Clears `retry_cnt` and `fault`.
  - Takes priority over every other transition in that cycle.
  - Leaves `loss_count` unchanged.
- All outputs are registered Moore outputs decoded from the state register.
  - Exception: `lock_lost` is registered on the RUN→RESET_HOLD transition.
  - `pll_rst` and `sys_rst_n` never glitch.
- Reset (`rst_n`=0), asynchronous, in any state including mid-operation:
  - state=RESET_HOLD, counter=0, `retry_cnt`=0, synchronizer=0.
  - `pll_rst`=1, `sys_rst_n`=0, `fault`=0, `lock_lost`=0, `loss_count`=0.

## Timing
- After `rst_n` deasserts, `pll_rst` stays high for exactly RST_HOLD_CYCLES cycles.
- `locked` rise first captured at edge k:
  - `locked_s`=1 after k+1.
  - STABILIZE after k+2.
  - RUN and `sys_rst_n`=1 after edge k+2+LOCK_STABLE_CYCLES.
- `locked` fall first captured at edge k while in RUN:
  - After k+2: `sys_rst_n`=0, `pll_rst`=1, and `lock_lost`=1 for exactly one cycle.
  - `loss_count` updates in the same cycle.
- Failed attempt length:
  - Timeout: RST_HOLD_CYCLES + LOCK_TIMEOUT_CYCLES cycles.
  - FAULT is entered after (MAX_RETRIES+1) failed attempts.
- `restart` sampled at edge k: state=RESET_HOLD after k+1.
- `locked_s` high during RESET_HOLD is ignored. A stale lock cannot skip the hold.

## Test plan
Bench parameters: RST_HOLD_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
- Release `rst_n`; `locked` rises 10 cycles later → `pll_rst` is high for exactly 4 cycles, then `sys_rst_n` rises exactly 10 cycles after `locked` is first sampled high, and `state`=3.
- `locked` held 0 → 3 attempts of 24 cycles each, then `fault`=1 at cycle 72, `pll_rst`=1 steady, and `sys_rst_n` never rises.
- `locked` drops for 3 cycles midway through STABILIZE → return to RESET_HOLD and `retry_cnt`=1; after relock, `sys_rst_n` rises and `retry_cnt` clears.
- `locked` falls in RUN → `sys_rst_n`=0 two cycles later, `lock_lost` high for one cycle, `loss_count`=1; the sequence then repeats to RUN; after 300 forced losses, `loss_count`=255.
- In FAULT, pulse `restart` → `fault`=0 and `state`=0 the next cycle, and `pll_rst` is held for 4 cycles.
- Assert `rst_n` mid-STABILIZE → all outputs take reset values immediately without waiting for a clock edge, and the sequence restarts cleanly.
